if_id_queue: RTL and testbench
==============================

# if_id_queue

- Parametrised successor to the single-entry IF/ID latch.
- A DEPTH-entry instruction queue between fetch and decode with a valid/ready handshake on the fetch side, decode-side stall, and synchronous branch/jump flush.
- Decouples fetch from decode stalls so fetch can run ahead by up to DEPTH instructions.
- Decode sees a NOP (PC 0, instruction 0) whenever no valid instruction is held.

## Interface
Parameters:
- PC_W, 32, width of the PC+4 field
- INST_W, 32, width of the instruction word
- DEPTH, 4, number of entries; power of two, at least 2
- ZERO_BUBBLE, 1, when 1, pc_o/inst_o are forced to 0 while valid_o=0; when 0, they show stale head storage

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  pipeline clock; all state updates on the rising edge
- rst_n_i  in  1  asynchronous active-low reset
- valid_i  in  1  fetch presents an instruction
- addedPC_i  in  PC_W  PC+4 of the fetched instruction
- inst_i  in  INST_W  fetched instruction
- ready_o  out  1  queue can accept this cycle
- stall_i  in  1  decode/hazard unit holds the head entry
- flush_i  in  1  branch or jump taken; discard all queued and incoming entries
- valid_o  out  1  head entry valid toward decode
- addedPC_o  out  PC_W  head PC+4
- inst_o  out  INST_W  head instruction
- count_o  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Handshakes:
  - push = valid_i & ready_o
  - pop = valid_o & ~stall_i
- ready_o = (count < DEPTH). It depends on state only; there is no combinational path from stall_i to ready_o. A full queue refuses a push even if a pop happens in the same cycle.
- valid_o = (count != 0).
- Outputs depend on registered state only; no combinational path from any input to any output.
- Storage:
  - circular buffer with write pointer wp and read pointer rp, each $clog2(DEPTH) bits
  - pointers wrap naturally from DEPTH-1 to 0
  - count is kept separately; full and empty are distinguished by count, never by pointer compare
- Per-edge priority:
  - flush_i=1: wp=rp=0 and count=0. Any push or pop in the same cycle is ignored; the incoming instruction is wrong-path and is dropped.
  - otherwise on push: write at wp, then wp+1.
  - otherwise on pop: rp+1.
  - count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop with count=1: the new entry becomes head on the next cycle; valid_o stays 1.
- Stall while empty has no effect. stall_i is ignored when valid_o=0.
- Output data:
  - addedPC_o/inst_o = mem[rp] when valid_o=1
  - when valid_o=0 and ZERO_BUBBLE=1: both 0 (NOP bubble)
- Flush clears only control state; the storage array is not cleared.

## Timing
- Reset value of every output (immediately on asynchronous assertion):
  - valid_o=0, addedPC_o=0, inst_o=0, count_o=0
  - ready_o=1
  - pointers 0
- Reset mid-operation discards all entries. Release is synchronised by the integrator; the block adds no reset synchroniser.
- Latency: an entry pushed at edge N into an empty queue is on the outputs during cycle N+1. Fall-through within one cycle is not supported.
- Throughput: one push and one pop per cycle sustained at any occupancy below DEPTH.
- Flush at edge N: valid_o=0 during cycle N+1. A push at edge N+1 is accepted normally.
- Flush on the same edge as reset release: reset state wins; the flush is a no-op.

## Structure
- Shared package if_id_pkg:
  - NOP_INST = 0
  - count width function clog2_p1(DEPTH) returning $clog2(DEPTH+1)
- One sub-module, if_id_queue_mem:
  - DEPTH x (PC_W+INST_W) flop array
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata)
  - no reset on the array
- Pointer, count and flush control stay in if_id_queue.

## Test plan
- Reset: hold rst_n_i=0 with valid_i=1, inst_i=32'h8C220004 -> valid_o=0, inst_o=0, count_o=0, ready_o=1; no entry stored after release.
- Fill and drain: push 4 instructions (0x11, 0x22, 0x33, 0x44; PC 4, 8, 12, 16) with stall_i=1.
  - After fill: count_o=4, ready_o=0; a fifth push is refused.
  - After release: pops in order 0x11..0x44, one per cycle, then valid_o=0 and inst_o=0.
- Wrap-around: 10 cycles of continuous push and pop with stall_i=0 -> count_o holds at 1; inst_o sequence matches input delayed by one cycle across pointer wrap.
- Flush: count=3 and flush_i=1 with a simultaneous push of 0x55 -> next cycle count_o=0, valid_o=0, inst_o=0; 0x55 never appears on the outputs.
- Stall hold: stall_i=1 for 3 cycles with head 0x22 -> inst_o=0x22, addedPC_o=8 steady all 3 cycles; pops on the first cycle with stall_i=0.
- ZERO_BUBBLE=0 build: empty after popping 0x44 -> valid_o=0 and inst_o still shows stale storage. The bench checks that valid_o gates use of the data.

Source files
------------

// File: rtl/if_id_pkg.sv
// if_id_pkg: shared constants and width helper for the IF/ID instruction queue
package if_id_pkg;
  localparam logic [31:0] NOP_INST = '0;
  function automatic int clog2_p1(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: unreset flop array, one sync write port, one async read port
module if_id_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  // storage holds no reset; control state alone decides which entries are live
  always_ff @(posedge clk_i)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry fetch-to-decode queue with stall, flush and NOP bubble
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int INST_W      = 32,
  parameter int DEPTH       = 4,
  parameter int ZERO_BUBBLE = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       valid_i,
  input  logic [PC_W-1:0]            addedPC_i,
  input  logic [INST_W-1:0]          inst_i,
  output logic                       ready_o,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       valid_o,
  output logic [PC_W-1:0]            addedPC_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [clog2_p1(DEPTH)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_p1(DEPTH);
  logic [AW-1:0]          wp, rp;
  logic [CW-1:0]          count;
  logic                   push, pop;
  logic [PC_W+INST_W-1:0] rdata;
  assign ready_o = count < CW'(DEPTH);
  assign valid_o = count != '0;
  assign count_o = count;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ~stall_i;
  if_id_queue_mem #(.DEPTH(DEPTH), .W(PC_W + INST_W)) u_mem (
    .clk_i (clk_i),
    .we    (push & ~flush_i),
    .waddr (wp),
    .wdata ({addedPC_i, inst_i}),
    .raddr (rp),
    .rdata (rdata)
  );
  assign addedPC_o = (ZERO_BUBBLE != 0 && !valid_o) ? '0 : rdata[PC_W+INST_W-1:INST_W];
  assign inst_o    = (ZERO_BUBBLE != 0 && !valid_o) ? INST_W'(NOP_INST) : rdata[INST_W-1:0];
  // flush discards everything including this cycle's push; otherwise pointers advance per handshake
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: scoreboard bench for the IF/ID queue, directed vectors
module tb_if_id_queue;
  localparam int DEPTH = 4;
  logic        clk_i = 0;
  logic        rst_n_i = 0;
  logic        valid_i = 0, stall_i = 0, flush_i = 0;
  logic [31:0] addedPC_i = 0, inst_i = 0;
  logic        ready_o, valid_o;
  logic [31:0] addedPC_o, inst_o;
  logic [2:0]  count_o;
  logic        ready_z, valid_z;
  logic [31:0] pc_z, inst_z;
  logic [2:0]  count_z;
  int          n_chk = 0, n_fail = 0;
  logic [63:0] q[$];
  int          cnt = 0;
  logic        mon_en = 0;

  always #5 clk_i = ~clk_i;

  if_id_queue #(.DEPTH(DEPTH), .ZERO_BUBBLE(1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .addedPC_i(addedPC_i),
    .inst_i(inst_i), .ready_o(ready_o), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_o), .addedPC_o(addedPC_o), .inst_o(inst_o), .count_o(count_o)
  );

  if_id_queue #(.DEPTH(DEPTH), .ZERO_BUBBLE(0)) dut_z (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .addedPC_i(addedPC_i),
    .inst_i(inst_i), .ready_o(ready_z), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_z), .addedPC_o(pc_z), .inst_o(inst_z), .count_o(count_z)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle of stimulus; the reference model advances on the edge
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic fl);
    logic push_ok, pop_ok;
    valid_i = v; addedPC_i = pc; inst_i = ins; stall_i = st; flush_i = fl;
    @(posedge clk_i);
    if (fl) begin
      q.delete();
      cnt = 0;
    end else begin
      push_ok = v && cnt < DEPTH;
      pop_ok  = cnt != 0 && !st;
      if (push_ok) q.push_back({pc, ins});
      cnt = cnt + int'(push_ok) - int'(pop_ok);
    end
    #1;
  endtask

  // monitor: compares occupancy, flags and head entry; retires the head when decode takes it
  always @(negedge clk_i) if (mon_en) begin
    chk("count", 64'(count_o), 64'(q.size()));
    chk("ready", 64'(ready_o), 64'(q.size() < DEPTH));
    chk("valid", 64'(valid_o), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_pc", 64'(addedPC_o), 64'(q[0][63:32]));
      chk("head_inst", 64'(inst_o), 64'(q[0][31:0]));
      if (!stall_i && !flush_i) void'(q.pop_front());
    end else begin
      chk("bubble_pc", 64'(addedPC_o), 64'h0);
      chk("bubble_inst", 64'(inst_o), 64'h0);
    end
  end

  initial begin
    valid_i = 1; inst_i = 32'h8C220004; addedPC_i = 32'd4;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_inst", 64'(inst_o), 64'h0);
    chk("rst_pc", 64'(addedPC_o), 64'h0);
    chk("rst_count", 64'(count_o), 64'h0);
    chk("rst_ready", 64'(ready_o), 64'h1);
    @(posedge clk_i); #1;
    valid_i = 0;
    rst_n_i = 1;
    mon_en = 1;
    drive(0, 0, 0, 0, 0);
    // fill with decode stalled, then one refused push
    drive(1, 4,  32'h11, 1, 0);
    drive(1, 8,  32'h22, 1, 0);
    drive(1, 12, 32'h33, 1, 0);
    drive(1, 16, 32'h44, 1, 0);
    drive(1, 20, 32'h99, 1, 0);
    // drain in order
    repeat (4) drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("stale_valid", 64'(valid_z), 64'h0);
    chk("stale_inst", 64'(inst_z), 64'h11);
    chk("stale_pc", 64'(pc_z), 64'h4);
    @(posedge clk_i); #1;
    // continuous push and pop across pointer wrap
    for (int i = 0; i < 10; i++) drive(1, 32'(100 + 4 * i), 32'(32'hA0 + i), 0, 0);
    drive(0, 0, 0, 0, 0);
    // stall hold on head 0x22
    drive(1, 8,  32'h22, 1, 0);
    drive(1, 12, 32'h23, 1, 0);
    repeat (3) drive(0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    // flush with simultaneous push
    drive(1, 4,  32'h31, 1, 0);
    drive(1, 8,  32'h32, 1, 0);
    drive(1, 12, 32'h33, 1, 0);
    drive(1, 16, 32'h55, 1, 1);
    @(negedge clk_i);
    chk("flush_count", 64'(count_o), 64'h0);
    chk("flush_valid", 64'(valid_o), 64'h0);
    chk("flush_inst", 64'(inst_o), 64'h0);
    @(posedge clk_i); #1;
    drive(1, 20, 32'h66, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // stall while empty changes nothing
    drive(0, 0, 0, 1, 0);
    mon_en = 0;
    chk("sb_empty", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
